// File: rtl/hazard_sb_pkg.sv
// +------------------------------------------------------------------+
// | hazard_sb_pkg : shared stage indices, drain states, select type  |
// | Revision      : 1.0                                              |
// +------------------------------------------------------------------+
`default_nettype none

package hazard_sb_pkg;
  localparam int STG_F = 0;
  localparam int STG_D = 1;
  localparam int STG_E = 2;
  localparam int STG_M = 3;

  // Select width of the default 4-back-stage configuration.
  localparam int FWD_SEL_W = 3;
  typedef logic [FWD_SEL_W-1:0] fwd_sel_t;

  // Bit 0 = I-side response pending, bit 1 = D-side response pending.
  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    DRAIN_I  = 2'b01,
    DRAIN_D  = 2'b10,
    DRAIN_ID = 2'b11
  } drain_state_t;
endpackage

`default_nettype wire

// File: rtl/hazard_scoreboard.sv
// +------------------------------------------------------------------+
// | hazard_scoreboard : busy bitmap for multi-cycle results          |
// | Revision          : 1.0                                          |
// +------------------------------------------------------------------+
`default_nettype none

module hazard_scoreboard #(
  parameter int NREG = 32,
  parameter int RW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            mc_issue,
  input  logic [RW-1:0]   mc_dst,
  input  logic            mc_done,
  input  logic [RW-1:0]   mc_done_dst,
  output logic [NREG-1:0] busy
);
  logic [NREG-1:0] busy_d, busy_q;

  // Set is applied after clear so a same-cycle issue on the same register wins.
  always_comb begin
    busy_d = busy_q;
    if (mc_done) busy_d[mc_done_dst] = 1'b0;
    if (mc_issue && (mc_dst != '0)) busy_d[mc_dst] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) busy_q <= '0;
    else         busy_q <= busy_d;
  end

  assign busy = busy_q;
endmodule

`default_nettype wire

// File: rtl/hazard_sb.sv
// +------------------------------------------------------------------+
// | hazard_sb : stall/flush/forward control with mc scoreboard+drain |
// | Revision  : 1.0                                                  |
// +------------------------------------------------------------------+
`default_nettype none

module hazard_sb
  import hazard_sb_pkg::*;
#(
  parameter int NREG    = 32,
  parameter int NSRC    = 2,
  parameter int NSTG    = 4,
  parameter int MEM_STG = 2,
  parameter int RW      = $clog2(NREG),
  parameter int SELW    = $clog2(NSTG+1)
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [NSRC*RW-1:0]   src_d,
  input  logic [NSRC*RW-1:0]   src_e,
  input  logic [NSTG*RW-1:0]   dst,
  input  logic [NSTG-1:0]      wr,
  input  logic [NSTG-1:0]      ldpend,
  input  logic                 dbranch,
  input  logic                 dbranch_use,
  input  logic                 mc_issue,
  input  logic [RW-1:0]        mc_dst,
  input  logic                 mc_done,
  input  logic [RW-1:0]        mc_done_dst,
  input  logic                 redirect,
  input  logic                 i_wait,
  input  logic                 d_wait,
  input  logic                 e_wait,
  output logic [NSTG+1:0]      stall,
  output logic [NSTG+1:0]      flush,
  output logic [NSRC*SELW-1:0] fwd_d,
  output logic [NSRC*SELW-1:0] fwd_e,
  output logic [NREG-1:0]      sb_busy
);
  logic [NREG-1:0] busy;
  logic [NSRC-1:0] hz_src;
  logic            hz;

  hazard_scoreboard #(.NREG(NREG), .RW(RW)) u_sb (
    .clk         (clk),
    .resetn      (resetn),
    .mc_issue    (mc_issue),
    .mc_dst      (mc_dst),
    .mc_done     (mc_done),
    .mc_done_dst (mc_done_dst),
    .busy        (busy)
  );
  assign sb_busy = busy;

  for (genvar s = 0; s < NSRC; s++) begin : g_src
    logic [RW-1:0]   rd, re;
    logic [SELW-1:0] sel_d, sel_e;
    logic            ld_hz;

    assign rd = src_d[s*RW +: RW];
    assign re = src_e[s*RW +: RW];

    // Oldest-to-youngest scan, so the youngest matching stage is the one kept.
    always_comb begin
      sel_d = '0;
      ld_hz = 1'b0;
      for (int k = NSTG-1; k >= 0; k--) begin
        if (wr[k] && (dst[k*RW +: RW] == rd)) begin
          sel_d = ldpend[k] ? '0 : SELW'(k+1);
          ld_hz = ldpend[k];
        end
      end
      if (rd == '0) begin
        sel_d = '0;
        ld_hz = 1'b0;
      end
    end

    always_comb begin
      sel_e = '0;
      for (int k = NSTG-1; k >= 1; k--) begin
        if (wr[k] && (dst[k*RW +: RW] == re)) sel_e = ldpend[k] ? '0 : SELW'(k+1);
      end
      if (re == '0) sel_e = '0;
    end

    assign fwd_d[s*SELW +: SELW] = sel_d;
    assign fwd_e[s*SELW +: SELW] = sel_e;
    assign hz_src[s] = ld_hz | busy[rd]
                     | (dbranch_use & wr[0] & (dst[RW-1:0] == rd) & (rd != '0))
                     | (mc_issue & (mc_dst == rd) & (rd != '0));
  end

  assign hz = |hz_src;

  logic [NSTG+1:0] stall_p, flush_p;

  always_comb begin
    stall_p = '0;
    flush_p = '0;
    if (redirect) begin
      for (int i = 1; i <= NSTG+1; i++) flush_p[i] = 1'b1;
    end else if (e_wait) begin
      stall_p[STG_F] = 1'b1;
      stall_p[STG_D] = 1'b1;
      stall_p[STG_E] = 1'b1;
      if (d_wait) stall_p[STG_M] = 1'b1;
      else        flush_p[STG_M] = 1'b1;
    end else if (d_wait) begin
      for (int i = 0; i <= NSTG+1; i++) begin
        stall_p[i] = (i <= MEM_STG+2);
        flush_p[i] = (i == MEM_STG+3);
      end
    end else if (i_wait) begin
      stall_p[STG_F] = 1'b1;
      if (hz || dbranch) begin
        stall_p[STG_D] = 1'b1;
        flush_p[STG_E] = 1'b1;
      end else begin
        flush_p[STG_D] = 1'b1;
      end
    end else begin
      stall_p[STG_F] = hz;
      stall_p[STG_D] = hz;
      flush_p[STG_E] = hz;
      flush_p[STG_D] = dbranch & ~hz;
    end
  end

  drain_state_t state_d, state_q;
  logic         pend_i, pend_d, drain_stall_f, drain_fl_d, drain_fl_m;

  always_comb begin
    pend_i        = (state_q == DRAIN_I) || (state_q == DRAIN_ID);
    pend_d        = (state_q == DRAIN_D) || (state_q == DRAIN_ID);
    drain_stall_f = pend_i & i_wait;
    drain_fl_d    = pend_i & ~i_wait;
    drain_fl_m    = pend_d & ~d_wait;
    state_d = drain_state_t'({(pend_d | redirect) & d_wait, (pend_i | redirect) & i_wait});
  end

  always_ff @(posedge clk) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Outputs are held quiet while reset is asserted so no stale drain pulse escapes.
  always_comb begin
    stall = '0;
    flush = '0;
    if (resetn) begin
      stall = stall_p;
      flush = flush_p;
      stall[STG_F] = stall_p[STG_F] | drain_stall_f;
      flush[STG_D] = flush_p[STG_D] | drain_fl_d;
      for (int i = 0; i <= NSTG+1; i++) begin
        if (i == MEM_STG+3) flush[i] = flush_p[i] | drain_fl_m;
      end
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_hazard_sb.sv
// +------------------------------------------------------------------+
// | tb_hazard_sb : scoreboard-queue bench for hazard_sb              |
// | Revision     : 1.0                                               |
// +------------------------------------------------------------------+
`default_nettype none

module tb_hazard_sb;
  localparam int RW = 5;

  logic        clk = 1'b0;
  logic        resetn;
  logic [9:0]  src_d, src_e;
  logic [19:0] dst;
  logic [3:0]  wr, ldpend;
  logic        dbranch, dbranch_use, mc_issue, mc_done, redirect;
  logic [4:0]  mc_dst, mc_done_dst;
  logic        i_wait, d_wait, e_wait;
  logic [5:0]  stall, flush, fwd_d, fwd_e;
  logic [31:0] sb_busy;

  hazard_sb dut (
    .clk(clk), .resetn(resetn), .src_d(src_d), .src_e(src_e), .dst(dst),
    .wr(wr), .ldpend(ldpend), .dbranch(dbranch), .dbranch_use(dbranch_use),
    .mc_issue(mc_issue), .mc_dst(mc_dst), .mc_done(mc_done),
    .mc_done_dst(mc_done_dst), .redirect(redirect), .i_wait(i_wait),
    .d_wait(d_wait), .e_wait(e_wait), .stall(stall), .flush(flush),
    .fwd_d(fwd_d), .fwd_e(fwd_e), .sb_busy(sb_busy)
  );

  always #5 clk = ~clk;

  localparam int S_STALL = 0, S_FLUSH = 1, S_FWDD = 2, S_FWDE = 3, S_BUSY = 4;

  typedef struct {
    string       tag;
    int          sig;
    logic [31:0] val;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input int sig, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.val = val;
    q.push_back(e);
  endtask

  task automatic push_sf(input string tag, input logic [5:0] st, input logic [5:0] fl);
    push_exp({tag, ".stall"}, S_STALL, 32'(st));
    push_exp({tag, ".flush"}, S_FLUSH, 32'(fl));
  endtask

  // Outputs are sampled on the falling edge; inputs change 1ns after the rising edge.
  task automatic step();
    exp_t        e;
    logic [31:0] obs;
    @(negedge clk);
    while (q.size() > 0) begin
      e = q.pop_front();
      case (e.sig)
        S_STALL: obs = 32'(stall);
        S_FLUSH: obs = 32'(flush);
        S_FWDD:  obs = 32'(fwd_d);
        S_FWDE:  obs = 32'(fwd_e);
        default: obs = sb_busy;
      endcase
      check_val(e.tag, obs, e.val);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    src_d = '0; src_e = '0; dst = '0; wr = '0; ldpend = '0;
    dbranch = 0; dbranch_use = 0; mc_issue = 0; mc_dst = '0;
    mc_done = 0; mc_done_dst = '0; redirect = 0;
    i_wait = 0; d_wait = 0; e_wait = 0;
  endtask

  task automatic set_dst(input int k, input logic [4:0] r);
    dst[k*RW +: RW] = r;
  endtask

  initial begin
    quiet();
    resetn = 0;
    push_sf("rst", 6'b000000, 6'b000000);
    push_exp("rst.busy", S_BUSY, 32'h0);
    step();
    resetn = 1;

    // Load-use in decode
    set_dst(0, 5); wr = 4'b0001; ldpend = 4'b0001; src_d[4:0] = 5;
    push_sf("lduse", 6'b000011, 6'b000100);
    push_exp("lduse.fwd_d", S_FWDD, 32'h0);
    step();
    ldpend = 4'b0000;
    push_sf("fwd_d_e", 6'b000000, 6'b000000);
    push_exp("fwd_d_e.sel", S_FWDD, 32'd1);
    step();

    // Execute forwarding priority
    quiet();
    set_dst(1, 7); set_dst(3, 7); wr = 4'b1010; src_e[9:5] = 7;
    push_exp("fwde.m", S_FWDE, 32'd2 << 3);
    step();
    wr = 4'b1000;
    push_exp("fwde.w", S_FWDE, 32'd4 << 3);
    step();
    src_e[9:5] = 0;
    push_exp("fwde.r0", S_FWDE, 32'd0);
    step();
    src_e[9:5] = 7; wr = 4'b1010; ldpend = 4'b0010;
    push_exp("fwde.ldm", S_FWDE, 32'd0);
    step();
    quiet();
    set_dst(0, 7); wr = 4'b0001; src_e[4:0] = 7;
    push_exp("fwde.noe", S_FWDE, 32'd0);
    step();

    // Branch compare hazard
    quiet();
    dbranch = 1; dbranch_use = 1; set_dst(0, 4); wr = 4'b0001; src_d[9:5] = 4;
    push_sf("brhz", 6'b000011, 6'b000100);
    step();
    src_d[9:5] = 6;
    push_sf("brtaken", 6'b000000, 6'b000010);
    step();

    // Multi-cycle scoreboard
    quiet();
    mc_issue = 1; mc_dst = 9; src_d[4:0] = 9;
    push_sf("mc.issue", 6'b000011, 6'b000100);
    push_exp("mc.issue.busy", S_BUSY, 32'h0);
    step();
    mc_issue = 0;
    for (int c = 0; c < 2; c++) begin
      push_sf("mc.wait", 6'b000011, 6'b000100);
      push_exp("mc.wait.busy", S_BUSY, 32'h200);
      step();
    end
    mc_done = 1; mc_done_dst = 9;
    push_sf("mc.done", 6'b000011, 6'b000100);
    step();
    mc_done = 0;
    push_sf("mc.after", 6'b000000, 6'b000000);
    push_exp("mc.after.busy", S_BUSY, 32'h0);
    step();
    quiet();
    mc_issue = 1; mc_dst = 9;
    step();
    mc_done = 1; mc_done_dst = 9;
    step();
    quiet();
    push_exp("mc.setwins", S_BUSY, 32'h200);
    mc_done = 1; mc_done_dst = 9;
    step();
    quiet();
    push_exp("mc.cleared", S_BUSY, 32'h0);
    mc_issue = 1; mc_dst = 0;
    step();
    quiet();
    push_exp("mc.r0", S_BUSY, 32'h0);
    step();

    // Priority of wait sources
    quiet(); e_wait = 1;
    push_sf("ewait", 6'b000111, 6'b001000);
    step();
    d_wait = 1;
    push_sf("ewait_dwait", 6'b001111, 6'b000000);
    step();
    e_wait = 0;
    push_sf("dwait", 6'b011111, 6'b100000);
    step();
    quiet(); i_wait = 1;
    push_sf("iwait", 6'b000001, 6'b000010);
    step();
    dbranch = 1;
    push_sf("iwait_br", 6'b000011, 6'b000100);
    step();

    // Redirect under i_wait
    quiet(); redirect = 1; i_wait = 1;
    push_sf("rdI.c0", 6'b000000, 6'b111110);
    step();
    redirect = 0;
    for (int c = 1; c < 3; c++) begin
      push_sf("rdI.wait", 6'b000001, 6'b000010);
      step();
    end
    i_wait = 0;
    push_sf("rdI.pulse", 6'b000000, 6'b000010);
    step();
    push_sf("rdI.idle", 6'b000000, 6'b000000);
    step();

    // Redirect with both waits, D side finishes first
    quiet(); redirect = 1; i_wait = 1; d_wait = 1;
    push_sf("rdID.c0", 6'b000000, 6'b111110);
    step();
    redirect = 0;
    push_sf("rdID.c1", 6'b011111, 6'b100000);
    step();
    d_wait = 0;
    push_sf("rdID.dpulse", 6'b000001, 6'b100010);
    step();
    push_sf("rdID.c3", 6'b000001, 6'b000010);
    step();
    i_wait = 0;
    push_sf("rdID.ipulse", 6'b000000, 6'b000010);
    step();
    push_sf("rdID.idle", 6'b000000, 6'b000000);
    step();

    // Both waits fall together
    quiet(); redirect = 1; i_wait = 1; d_wait = 1;
    step();
    quiet();
    push_sf("rdBoth.pulse", 6'b000000, 6'b100010);
    step();
    push_sf("rdBoth.idle", 6'b000000, 6'b000000);
    step();

    // Reset while draining with a busy register
    quiet(); redirect = 1; i_wait = 1; d_wait = 1; mc_issue = 1; mc_dst = 3;
    push_sf("rstd.c0", 6'b000000, 6'b111110);
    step();
    quiet(); resetn = 0;
    push_sf("rstd.inrst", 6'b000000, 6'b000000);
    push_exp("rstd.inrst.busy", S_BUSY, 32'h8);
    step();
    resetn = 1;
    push_sf("rstd.after", 6'b000000, 6'b000000);
    push_exp("rstd.after.busy", S_BUSY, 32'h0);
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

`default_nettype wire
